// File: rtl/detect_stretcher_if.sv
// Bundle of control inputs and stretched-detect outputs for detect_stretcher.
// The master side drives events and configuration; the slave side is the stretcher.
interface detect_stretcher_if #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = 25,
  parameter int unsigned EVT_W = 16
);
  logic                  clear;
  logic [N_CH-1:0]       event_in;
  logic [N_CH*CNT_W-1:0] target;
  logic [N_CH-1:0]       retrig;
  logic [N_CH-1:0]       active;
  logic [N_CH*EVT_W-1:0] event_count;
  logic                  any_active;

  modport master (
    output clear, event_in, target, retrig,
    input  active, event_count, any_active
  );

  modport slave (
    input  clear, event_in, target, retrig,
    output active, event_count, any_active
  );
endinterface

// File: rtl/detect_stretcher.sv
// Per-channel pulse stretcher: a rising edge on event_in holds active for target cycles,
// with a saturating trigger counter. Define DETECT_SYNC_EN to add a 2-flop input synchroniser.
module detect_stretcher #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = 25,
  parameter int unsigned EVT_W = 16
) (
  input logic               clk,
  input logic               rst,
  detect_stretcher_if.slave bus
);

  typedef enum logic {StIdle, StActive} state_e;

  logic [N_CH-1:0]       ev;
  logic [N_CH-1:0]       ev_d;
  logic [N_CH-1:0]       trig;
  logic [N_CH-1:0]       act_next;
  logic [N_CH-1:0]       active_w;
  logic [N_CH*EVT_W-1:0] count_w;
  logic                  any_active_q;

`ifdef DETECT_SYNC_EN
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.event_in;
      sync2 <= sync1;
    end
  end

  assign ev = sync2;
`else
  assign ev = bus.event_in;
`endif

  // Edge history keeps running through clear so a held level cannot re-trigger afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_d <= '0;
    end else begin
      ev_d <= ev;
    end
  end

  assign trig = ev & ~ev_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] tgt;
    logic [CNT_W-1:0] eff_m1;
    logic [EVT_W-1:0] cnt;
    logic             expire;

    assign tgt    = bus.target[i*CNT_W +: CNT_W];
    // A zero target behaves as one, so eff_target-1 is zero in both cases.
    assign eff_m1 = (tgt == '0) ? '0 : tgt - CNT_W'(1);
    assign expire = (timer >= eff_m1);

    assign act_next[i] = !bus.clear &&
                         ((state == StIdle) ? trig[i] : ((trig[i] && bus.retrig[i]) || !expire));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= StIdle;
        timer <= '0;
        cnt   <= '0;
      end else if (bus.clear) begin
        state <= StIdle;
        timer <= '0;
        cnt   <= '0;
      end else begin
        if (trig[i] && (cnt != '1)) begin
          cnt <= cnt + EVT_W'(1);
        end
        unique case (state)
          StIdle: begin
            if (trig[i]) begin
              state <= StActive;
              timer <= '0;
            end
          end
          StActive: begin
            if (trig[i] && bus.retrig[i]) begin
              timer <= '0;
            end else if (expire) begin
              state <= StIdle;
              timer <= '0;
            end else begin
              timer <= timer + CNT_W'(1);
            end
          end
          default: begin
            state <= StIdle;
            timer <= '0;
          end
        endcase
      end
    end

    assign active_w[i]                  = (state == StActive);
    assign count_w[i*EVT_W +: EVT_W]    = cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_active_q <= 1'b0;
    end else begin
      any_active_q <= |act_next;
    end
  end

  assign bus.active      = active_w;
  assign bus.event_count = count_w;
  assign bus.any_active  = any_active_q;

endmodule

// File: tb/tb_detect_stretcher.sv
// Randomised and directed self-checking bench for detect_stretcher against a
// cycle-age reference model (pulse lasts while age since (re)start < effective target).
module tb_detect_stretcher;
  localparam int unsigned N_CH  = 2;
  localparam int unsigned CNT_W = 25;
  localparam int unsigned EVT_W = 16;
  localparam int          CMAX  = (1 << EVT_W) - 1;
`ifdef DETECT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  detect_stretcher_if #(.N_CH(N_CH), .CNT_W(CNT_W), .EVT_W(EVT_W)) bus ();
  detect_stretcher #(.N_CH(N_CH), .CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  detect_stretcher_if #(.N_CH(1), .CNT_W(8), .EVT_W(4)) sbus ();
  detect_stretcher #(.N_CH(1), .CNT_W(8), .EVT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stimulus copies driven onto the bus before each edge.
  logic [N_CH-1:0] ev_v;
  logic [N_CH-1:0] rt_v;
  int              tgt_v [N_CH];
  logic            clr_v;

  // Reference model state.
  int now;
  bit m_act   [N_CH];
  int m_start [N_CH];
  int m_cnt   [N_CH];
  bit m_prev  [N_CH];
  bit m_s1    [N_CH];
  bit m_s2    [N_CH];

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_act[c] = 0; m_start[c] = 0; m_cnt[c] = 0;
      m_prev[c] = 0; m_s1[c] = 0; m_s2[c] = 0;
    end
  endtask

  task automatic model_step();
    now++;
    for (int c = 0; c < N_CH; c++) begin
      bit ev, trig;
      int eff;
      ev = (LAT == 2) ? m_s2[c] : ev_v[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = ev_v[c];
      trig = ev && !m_prev[c];
      m_prev[c] = ev;
      eff = (tgt_v[c] == 0) ? 1 : tgt_v[c];
      if (clr_v) begin
        m_act[c] = 0;
        m_cnt[c] = 0;
      end else begin
        if (trig && m_cnt[c] < CMAX) m_cnt[c]++;
        if (!m_act[c]) begin
          if (trig) begin
            m_act[c] = 1;
            m_start[c] = now;
          end
        end else if (trig && rt_v[c]) begin
          m_start[c] = now;
        end else if (now - m_start[c] >= eff) begin
          m_act[c] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    bit any;
    any = 0;
    for (int c = 0; c < N_CH; c++) begin
      check($sformatf("active%0d@%0d", c, now), 64'(bus.active[c]), 64'(m_act[c]));
      check($sformatf("count%0d@%0d", c, now), 64'(bus.event_count[c*EVT_W +: EVT_W]),
            64'(m_cnt[c]));
      any |= m_act[c];
    end
    check($sformatf("any_active@%0d", now), 64'(bus.any_active), 64'(any));
  endtask

  task automatic drive();
    bus.event_in = ev_v;
    bus.retrig   = rt_v;
    bus.clear    = clr_v;
    for (int c = 0; c < N_CH; c++) bus.target[c*CNT_W +: CNT_W] = CNT_W'(tgt_v[c]);
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Runs channel 0 for len cycles with one-cycle-high input where pulse_mask has ones.
  task automatic scenario(input string name, input int tgt, input bit rt,
                          input logic [63:0] pulse_mask, input int len,
                          input int exp_w, input int exp_cnt);
    int w, rise;
    ev_v[0] = 1'b0;
    clr_v   = 1'b1;
    tick();
    clr_v    = 1'b0;
    tgt_v[0] = tgt;
    rt_v[0]  = rt;
    w = 0;
    rise = -1;
    for (int c = 0; c < len; c++) begin
      ev_v[0] = pulse_mask[c];
      tick();
      if (bus.active[0]) begin
        w++;
        if (rise < 0) rise = c;
      end
    end
    ev_v[0] = 1'b0;
    check({name, "_width"}, 64'(w), 64'(exp_w));
    check({name, "_count"}, 64'(bus.event_count[EVT_W-1:0]), 64'(exp_cnt));
    if (pulse_mask[0]) check({name, "_rise"}, 64'(rise), 64'(LAT));
  endtask

  initial begin
    ev_v = '0; rt_v = '0; clr_v = 1'b0; now = 0;
    for (int c = 0; c < N_CH; c++) tgt_v[c] = 0;
    drive();
    sbus.clear = 1'b0; sbus.event_in = 1'b0; sbus.target = 8'd1; sbus.retrig = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("reset_sat_count", 64'(sbus.event_count), 64'd0);
    #2 rst = 1'b1;

    // Directed scenarios on channel 0.
    scenario("oneshot5", 5, 1'b0, 64'h1, 20, 5, 1);
    scenario("width3", 3, 1'b0, 64'h1, 12, 3, 1);
    scenario("retrig", 10, 1'b1, 64'h111, 40, 18, 3);
    scenario("ignore", 10, 1'b0, 64'h11, 30, 10, 2);
    scenario("expiry_oneshot", 5, 1'b0, 64'h21, 20, 5, 2);
    scenario("expiry_retrig", 5, 1'b1, 64'h21, 25, 10, 2);
    scenario("target0", 0, 1'b0, 64'h1, 10, 1, 1);
    scenario("level50", 5, 1'b1, 64'h3_FFFF_FFFF_FFFF, 60, 5, 1);

    // Clear held until the trig reaches the FSM: nothing starts, nothing counts.
    tgt_v[0] = 6; rt_v[0] = 1'b0;
    ev_v[0] = 1'b1; clr_v = 1'b1;
    repeat (LAT + 1) tick();
    check("clear_trig_active", 64'(bus.active[0]), 64'd0);
    check("clear_trig_count", 64'(bus.event_count[EVT_W-1:0]), 64'd0);
    clr_v = 1'b0;
    repeat (LAT + 2) tick();
    check("clear_no_retrig", 64'(bus.active[0]), 64'd0);

    // Reset mid-ACTIVE, then the held level produces one fresh trig.
    ev_v[0] = 1'b0; tick();
    tgt_v[0] = 20; ev_v[0] = 1'b1;
    repeat (LAT + 3) tick();
    check("pre_reset_active", 64'(bus.active[0]), 64'd1);
    rst = 1'b0;
    model_reset();
    #1;
    check("reset_async_active", 64'(bus.active[0]), 64'd0);
    check("reset_async_any", 64'(bus.any_active), 64'd0);
    check("reset_async_count", 64'(bus.event_count[EVT_W-1:0]), 64'd0);
    #1 rst = 1'b1;
    repeat (LAT + 1) tick();
    check("post_reset_active", 64'(bus.active[0]), 64'd1);
    check("post_reset_count", 64'(bus.event_count[EVT_W-1:0]), 64'd1);
    repeat (25) tick();
    ev_v[0] = 1'b0;
    tick();

    // Randomised run on both channels.
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(3) == 0) ev_v[c] = ~ev_v[c];
        if ($urandom_range(15) == 0) tgt_v[c] = int'($urandom_range(12));
        if ($urandom_range(31) == 0) rt_v[c] = 1'($urandom_range(1));
      end
      clr_v = ($urandom_range(63) == 0);
      tick();
    end
    ev_v = '0; clr_v = 1'b0;
    tick();

    // Saturation on the 4-bit counter instance.
    for (int p = 0; p < 20; p++) begin
      sbus.event_in = 1'b1; tick();
      sbus.event_in = 1'b0; tick();
      if (p == 14) begin
        repeat (LAT) tick();
        check("sat_at_max", 64'(sbus.event_count), 64'd15);
      end
    end
    repeat (LAT + 1) tick();
    check("sat_hold", 64'(sbus.event_count), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
